// File: rtl/pfir_interp_iq.sv
// Interpolating polyphase FIR for parallel X/Y samples; one MAC per clock per channel, L = intp+1 outputs per input.
// Build option ROUND_CONV_EN selects round-half-to-even on the output; the default build rounds half up.
module pfir_interp_iq #(
  parameter int DW = 18,
  parameter int CW = 18,
  parameter int AW = 5,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          mrst_n,
  input  logic [DW-1:0] dix,
  input  logic [DW-1:0] diy,
  input  logic          iv,
  output logic          rfd,
  input  logic          oe,
  output logic [DW-1:0] dox,
  output logic [DW-1:0] doy,
  output logic          ov,
  output logic          ovf,
  input  logic [3:0]    intp,
  input  logic [4:0]    ntap,
  input  logic [CW-1:0] pdata,
  input  logic          pwr,
  input  logic          prst
);
  localparam int PRW = DW + CW;
  localparam int ACW = DW + CW + 5;
  localparam int OSW = ACW - CW + 1;
  localparam logic [AW-1:0]          FILL_MAX = '1;
  localparam logic signed [ACW-1:0]  HALF     = ACW'(2 ** (CW - 2));
  localparam logic signed [ACW-1:0]  HALF_M1  = ACW'(2 ** (CW - 2) - 1);
  localparam logic signed [OSW-1:0]  SMAX     = OSW'(2 ** (DW - 1) - 1);
  localparam logic signed [OSW-1:0]  SMIN     = OSW'(-(2 ** (DW - 1)));

  typedef enum logic {IDLE, RUN} state_t;

  logic [CW-1:0] coef_mem [2**PW];
  logic [DW-1:0] xmem [2**AW];
  logic [DW-1:0] ymem [2**AW];

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, base_q, base_d, fill_q, fill_d, xaddr;
  logic [AW:0]   sfill_q, sfill_d;
  logic [1:0]    pend_q, pend_d, pend_eff;
  logic [PW-1:0] pctr_q, pctr_d, caddr_q, caddr_d;
  logic [3:0]    lm1_q, lm1_d, p_q, p_d;
  logic [4:0]    ntm1_q, ntm1_d, k_q, k_d;
  logic          accept, issue, tap_last, blk_done, start;

  logic [CW-1:0] c_rd_q;
  logic [DW-1:0] x_rd_q, y_rd_q;
  logic          s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d, s1_mask_q, s1_mask_d;
  logic          s2_v_q, s2_v_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic          s3_v_q, s3_v_d, s3_first_q, s3_first_d, s3_last_q, s3_last_d;
  logic          s4_last_q, s4_last_d;
  logic signed [DW-1:0]  s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic signed [CW-1:0]  s2_c_q, s2_c_d;
  logic signed [PRW-1:0] s3_px_q, s3_px_d, s3_py_q, s3_py_d;
  logic signed [ACW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [DW-1:0] dox_q, dox_d, doy_q, doy_d;
  logic          ov_q, ov_d, ovf_q, ovf_d;
  logic [DW:0]   rx, ry;

  // Returns {saturated, value} for one accumulator.
  function automatic logic [DW:0] rnd_sat(input logic signed [ACW-1:0] a);
    logic signed [ACW-1:0] b;
    logic signed [OSW-1:0] s;
`ifdef ROUND_CONV_EN
    b = a + HALF_M1 + ACW'(a[CW-1]);
`else
    b = a + HALF;
`endif
    s = OSW'(b >>> (CW - 1));
    if (s > SMAX)      rnd_sat = {1'b1, 1'b0, {(DW-1){1'b1}}};
    else if (s < SMIN) rnd_sat = {1'b1, 1'b1, {(DW-1){1'b0}}};
    else               rnd_sat = {1'b0, s[DW-1:0]};
  endfunction

  assign rfd = (pend_q < 2'd2);
  assign ov  = ov_q & oe;
  assign ovf = ovf_q;
  assign dox = dox_q;
  assign doy = doy_q;
  assign rx  = rnd_sat(acc_x_q);
  assign ry  = rnd_sat(acc_y_q);

  always_comb begin
    accept   = iv & rfd;
    issue    = (state_q == RUN) & oe;
    tap_last = (k_q == ntm1_q);
    blk_done = issue & tap_last & (p_q == lm1_q);
    // A finishing block with another sample queued restarts without passing through IDLE.
    start    = oe & (((state_q == IDLE) & (pend_q != 2'd0)) | (blk_done & (pend_q > 2'd1)));
    pend_eff = blk_done ? pend_q - 2'd1 : pend_q;
    xaddr    = base_q - AW'(k_q);

    state_d = state_q;  wptr_d = wptr_q;  base_d = base_q;  fill_d = fill_q;
    sfill_d = sfill_q;  pctr_d = pctr_q;  caddr_d = caddr_q;
    lm1_d   = lm1_q;    ntm1_d = ntm1_q;  p_d = p_q;        k_d = k_q;

    if (accept) begin
      wptr_d = wptr_q + AW'(1);
      if (fill_q != FILL_MAX) fill_d = fill_q + AW'(1);
    end
    pend_d = pend_q + 2'(accept) - 2'(blk_done);
    if (prst)     pctr_d = '0;
    else if (pwr) pctr_d = pctr_q + PW'(1);

    if (issue) begin
      caddr_d = caddr_q + PW'(1);
      if (tap_last) begin
        k_d = '0;
        p_d = p_q + 4'd1;
      end else begin
        k_d = k_q + 5'd1;
      end
    end
    if (blk_done) state_d = IDLE;
    if (start) begin
      state_d = RUN;
      lm1_d   = intp;
      ntm1_d  = ntap;
      p_d     = '0;
      k_d     = '0;
      caddr_d = '0;
      base_d  = wptr_q - AW'(pend_eff);
      // History length seen by this sample, including itself.
      sfill_d = {1'b0, fill_q} - (AW+1)'(pend_eff) + (AW+1)'(1);
    end

    s1_v_d = s1_v_q;  s1_first_d = s1_first_q;  s1_last_d = s1_last_q;  s1_mask_d = s1_mask_q;
    s2_v_d = s2_v_q;  s2_first_d = s2_first_q;  s2_last_d = s2_last_q;
    s3_v_d = s3_v_q;  s3_first_d = s3_first_q;  s3_last_d = s3_last_q;
    s4_last_d = s4_last_q;
    s2_x_d = s2_x_q;  s2_y_d = s2_y_q;  s2_c_d = s2_c_q;
    s3_px_d = s3_px_q;  s3_py_d = s3_py_q;
    acc_x_d = acc_x_q;  acc_y_d = acc_y_q;
    dox_d = dox_q;  doy_d = doy_q;  ov_d = ov_q;  ovf_d = ovf_q;

    if (oe) begin
      s1_v_d     = issue;
      s1_first_d = (k_q == 5'd0);
      s1_last_d  = tap_last;
      s1_mask_d  = ((AW+1)'(k_q) >= sfill_q);
      s2_v_d = s1_v_q;  s2_first_d = s1_first_q;  s2_last_d = s1_last_q;
      s2_x_d = s1_mask_q ? '0 : $signed(x_rd_q);
      s2_y_d = s1_mask_q ? '0 : $signed(y_rd_q);
      s2_c_d = $signed(c_rd_q);
      s3_v_d = s2_v_q;  s3_first_d = s2_first_q;  s3_last_d = s2_last_q;
      s3_px_d = PRW'(s2_x_q) * PRW'(s2_c_q);
      s3_py_d = PRW'(s2_y_q) * PRW'(s2_c_q);
      if (s3_v_q) begin
        acc_x_d = s3_first_q ? ACW'(s3_px_q) : acc_x_q + ACW'(s3_px_q);
        acc_y_d = s3_first_q ? ACW'(s3_py_q) : acc_y_q + ACW'(s3_py_q);
      end
      s4_last_d = s3_v_q & s3_last_q;
      ov_d      = s4_last_q;
      if (s4_last_q) begin
        dox_d = rx[DW-1:0];
        doy_d = ry[DW-1:0];
        ovf_d = rx[DW] | ry[DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pwr) coef_mem[pctr_q] <= pdata;
    if (accept) begin
      xmem[wptr_q] <= dix;
      ymem[wptr_q] <= diy;
    end
    if (oe) begin
      c_rd_q <= coef_mem[caddr_q];
      x_rd_q <= xmem[xaddr];
      y_rd_q <= ymem[xaddr];
    end
  end

  always_ff @(posedge clk) begin
    s2_x_q <= s2_x_d;    s2_y_q <= s2_y_d;    s2_c_q <= s2_c_d;
    s3_px_q <= s3_px_d;  s3_py_q <= s3_py_d;
    acc_x_q <= acc_x_d;  acc_y_q <= acc_y_d;
  end

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q <= IDLE;  wptr_q <= '0;  base_q <= '0;  fill_q <= '0;  sfill_q <= '0;
      pend_q <= '0;  pctr_q <= '0;  caddr_q <= '0;  lm1_q <= '0;  ntm1_q <= '0;
      p_q <= '0;  k_q <= '0;
      s1_v_q <= 1'b0;  s1_first_q <= 1'b0;  s1_last_q <= 1'b0;  s1_mask_q <= 1'b0;
      s2_v_q <= 1'b0;  s2_first_q <= 1'b0;  s2_last_q <= 1'b0;
      s3_v_q <= 1'b0;  s3_first_q <= 1'b0;  s3_last_q <= 1'b0;
      s4_last_q <= 1'b0;
      dox_q <= '0;  doy_q <= '0;  ov_q <= 1'b0;  ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;  wptr_q <= wptr_d;  base_q <= base_d;  fill_q <= fill_d;  sfill_q <= sfill_d;
      pend_q <= pend_d;  pctr_q <= pctr_d;  caddr_q <= caddr_d;  lm1_q <= lm1_d;  ntm1_q <= ntm1_d;
      p_q <= p_d;  k_q <= k_d;
      s1_v_q <= s1_v_d;  s1_first_q <= s1_first_d;  s1_last_q <= s1_last_d;  s1_mask_q <= s1_mask_d;
      s2_v_q <= s2_v_d;  s2_first_q <= s2_first_d;  s2_last_q <= s2_last_d;
      s3_v_q <= s3_v_d;  s3_first_q <= s3_first_d;  s3_last_q <= s3_last_d;
      s4_last_q <= s4_last_d;
      dox_q <= dox_d;  doy_q <= doy_d;  ov_q <= ov_d;  ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pfir_interp_iq.sv
// Scoreboard bench for pfir_interp_iq: a direct-convolution model queues expected outputs per accepted sample.
module tb_pfir_interp_iq;
  logic        clk = 1'b0;
  logic        mrst_n;
  logic [17:0] dix, diy, dox, doy, pdata;
  logic        iv, rfd, oe, ov, ovf, pwr, prst;
  logic [3:0]  intp;
  logic [4:0]  ntap;

  typedef struct { int x; int y; bit f; } exp_t;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t expq[$];
  int   coef [256];
  int   hx[$];
  int   hy[$];
  int   cur_l = 1;
  int   cur_nt = 1;
  bit   saw_rfd_low;
  exp_t mon_e;
  int   gx, gy;

  pfir_interp_iq dut (
    .clk(clk), .mrst_n(mrst_n), .dix(dix), .diy(diy), .iv(iv), .rfd(rfd), .oe(oe),
    .dox(dox), .doy(doy), .ov(ov), .ovf(ovf), .intp(intp), .ntap(ntap),
    .pdata(pdata), .pwr(pwr), .prst(prst)
  );

  always #5 clk = ~clk;

  // Scale a Q2.34 exact sum to Q1.17 with the selected rounding, then clamp.
  function automatic void rnd_sat_m(input longint v, output int r, output bit sat);
    longint q, rem;
    q   = v >>> 17;
    rem = v - q * 131072;
`ifdef ROUND_CONV_EN
    if (rem > 65536 || (rem == 65536 && (q % 2 != 0))) q = q + 1;
`else
    if (rem >= 65536) q = q + 1;
`endif
    sat = 1'b0;
    if (q > 131071) begin q = 131071; sat = 1'b1; end
    else if (q < -131072) begin q = -131072; sat = 1'b1; end
    r = int'(q);
  endfunction

  function automatic void model_accept(input int x, input int y);
    exp_t e;
    longint sx, sy;
    bit fx, fy;
    int n, c;
    hx.push_back(x);
    hy.push_back(y);
    n = hx.size() - 1;
    for (int p = 0; p < cur_l; p++) begin
      sx = 0;
      sy = 0;
      for (int k = 0; k < cur_nt; k++) begin
        if (n - k >= 0) begin
          c  = coef[(p * cur_nt + k) % 256];
          sx += longint'(c) * longint'(hx[n - k]);
          sy += longint'(c) * longint'(hy[n - k]);
        end
      end
      rnd_sat_m(sx, e.x, fx);
      rnd_sat_m(sy, e.y, fy);
      e.f = fx | fy;
      expq.push_back(e);
    end
  endfunction

  function automatic int rand18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  always @(negedge clk) begin
    if (ov === 1'b1) begin
      n_vec++;
      gx = int'($signed(dox));
      gy = int'($signed(doy));
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL out_extra: got x=%0d y=%0d ovf=%0b, required no output", gx, gy, ovf);
      end else begin
        mon_e = expq.pop_front();
        if (oe !== 1'b1 || gx != mon_e.x || gy != mon_e.y || ovf !== mon_e.f) begin
          n_bad++;
          $display("FAIL out_pair: got x=%0d y=%0d ovf=%0b oe=%0b, required x=%0d y=%0d ovf=%0b oe=1",
                   gx, gy, ovf, oe, mon_e.x, mon_e.y, mon_e.f);
        end else begin
          $display("out x=%0d y=%0d ovf=%0b ok", gx, gy, ovf);
        end
      end
    end
  end

  task automatic cycle(input bit v, input int x, input int y, input bit o, output bit acc);
    iv  = v;
    dix = 18'(x);
    diy = 18'(y);
    oe  = o;
    @(negedge clk);
    acc = v && (rfd === 1'b1);
    if (v && rfd !== 1'b1) saw_rfd_low = 1'b1;
    if (acc) model_accept(x, y);
    @(posedge clk);
    #1;
    iv = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int oe_pct);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc) begin
      cycle(1'b1, x, y, (int'($urandom_range(0, 99)) < oe_pct), acc);
      tries++;
      if (!acc && tries > 3000) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: rfd=%0b after %0d clocks, required 1", rfd, tries);
        return;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int t;
    t = 0;
    while (expq.size() != 0 && t < 6000) begin
      cycle(1'b0, 0, 0, 1'b1, acc);
      t++;
    end
    n_vec++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d outputs missing after %0d clocks, required 0", expq.size(), t);
      expq.delete();
    end
    repeat (4) cycle(1'b0, 0, 0, 1'b1, acc);
  endtask

  task automatic write_coefs(input int n);
    iv = 1'b0;
    oe = 1'b1;
    prst = 1'b1;
    @(posedge clk); #1;
    prst = 1'b0;
    for (int a = 0; a < n; a++) begin
      pwr = 1'b1;
      pdata = 18'(coef[a]);
      @(posedge clk); #1;
    end
    pwr = 1'b0;
  endtask

  task automatic set_cfg(input int l, input int nt);
    intp = 4'(l - 1);
    ntap = 5'(nt - 1);
    cur_l = l;
    cur_nt = nt;
  endtask

  task automatic do_reset();
    iv = 1'b0;
    mrst_n = 1'b0;
    #1;
    n_vec++;
    if (ov !== 1'b0 || rfd !== 1'b1 || dox !== 18'd0 || doy !== 18'd0 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got ov=%0b rfd=%0b dox=%0h doy=%0h ovf=%0b, required ov=0 rfd=1 dox=0 doy=0 ovf=0",
               ov, rfd, dox, doy, ovf);
    end else begin
      $display("reset ov=0 rfd=1 ok");
    end
    expq.delete();
    hx.delete();
    hy.delete();
    @(posedge clk);
    @(posedge clk); #1;
    mrst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int l, nt, nt_max, sh;
    mrst_n = 1'b1; iv = 1'b0; oe = 1'b1; dix = '0; diy = '0;
    pdata = '0; pwr = 1'b0; prst = 1'b0; intp = '0; ntap = '0;
    saw_rfd_low = 1'b0;
    for (int a = 0; a < 256; a++) coef[a] = 0;
    #2;
    do_reset();

    // Impulse response: 16 outputs walk c0,c4,c8,c12,c1,...
    for (int a = 0; a < 16; a++) coef[a] = a <<< 12;
    write_coefs(16);
    set_cfg(4, 4);
    send(65536, 65536, 100);
    repeat (3) send(0, 0, 100);
    drain();

    // DC gain from a clean history
    for (int a = 0; a < 4; a++) coef[a] = 65536;
    write_coefs(4);
    set_cfg(2, 2);
    do_reset();
    repeat (8) send(65536, 65536, 100);
    drain();

    // Saturation in both directions, then a small signal
    for (int a = 0; a < 4; a++) coef[a] = 131071;
    write_coefs(4);
    set_cfg(1, 4);
    repeat (6) send(131071, 4096, 100);
    repeat (6) send(-131072, -131072, 100);
    repeat (6) send(4096, 4096, 100);
    drain();

    // Backpressure: iv every clock, oe held low for 10 clocks mid-stream
    for (int a = 0; a < 4; a++) coef[a] = 65536;
    write_coefs(4);
    set_cfg(2, 2);
    saw_rfd_low = 1'b0;
    for (int c = 0; c < 60; c++) cycle(1'b1, rand18(), rand18(), !(c >= 20 && c < 30), acc);
    drain();
    n_vec++;
    if (!saw_rfd_low) begin
      n_bad++;
      $display("FAIL rfd_backpressure: rfd stayed 1 under continuous iv, required a drop to 0");
    end

    // Reset while filtering; history must read as masked afterwards
    repeat (3) send(65536, 65536, 100);
    repeat (3) cycle(1'b0, 0, 0, 1'b1, acc);
    do_reset();
    repeat (4) send(65536, 65536, 100);
    drain();

    // Rounding at exactly half an output LSB
    coef[0] = 1;
    write_coefs(1);
    set_cfg(1, 1);
    send(65536, -65536, 100);
    send(98304, 32768, 100);
    send(-65536, 65536, 100);
    drain();

    // Randomised configurations, coefficients, gaps and stalls
    for (int s = 0; s < 6; s++) begin
      l = int'($urandom_range(1, 16));
      nt_max = 128 / l;
      if (nt_max > 30) nt_max = 30;
      nt = int'($urandom_range(1, nt_max));
      sh = int'($urandom_range(0, 5));
      for (int a = 0; a < l * nt; a++) coef[a] = rand18() >>> sh;
      write_coefs(l * nt);
      set_cfg(l, nt);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) cycle(1'b0, 0, 0, 1'b1, acc);
        send(rand18(), rand18(), 75);
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
